bster_axi_ram: RTL and testbench

AXI4 slave (responder) memory holding the bster binary tree; it is the far end of the core's ram_axi_* master port. It accepts INCR/FIXED bursts on independent read and write paths, with one outstanding transaction per direction, byte-strobed writes and single-cycle back-to-back beats. It is used as the RAM behind the core in simulation and as the on-chip tree store in integrations.

---
 rtl/bster_pkg.sv | 22 ++
 rtl/bster_ram_array.sv | 37 +++
 rtl/bster_axi_ram.sv | 265 ++++++++++++++++++++++++++
 tb/tb_bster_axi_ram.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bster_pkg.sv
// bster_pkg: shared constants and state types for the bster AXI RAM.
// Contents: AXI burst/response encodings, write/read FSM state enums and a
// helper that gives the per-beat word-index step for a burst type.
package bster_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [1:0] AXI_BURST_RSVD  = 2'b11;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} write_state_t;
  typedef enum logic       {R_IDLE, R_BURST}        read_state_t;

  // FIXED holds the word index; everything else (WRAP included) steps by one.
  function automatic logic burst_step(input logic [1:0] burst);
    return burst != AXI_BURST_FIXED;
  endfunction

endpackage

// File: rtl/bster_ram_array.sv
// bster_ram_array: word-organised storage for the bster tree.
// Ports:
//   clk_i                      clock
//   we_i, waddr_i, wstrb_i,    write port, one byte enable per byte lane
//   wdata_i
//   re_i, raddr_i, rdata_o     registered read port; rdata_o holds while re_i=0
// A read and a write to the same word in one cycle return the old word.
module bster_ram_array #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 14,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
    for (int b = 0; b < STRB_W; b++) begin
      if (we_i && wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bster_axi_ram.sv
// bster_axi_ram: AXI4 responder memory holding the bster binary tree.
// Independent read/write paths, one outstanding burst per direction,
// INCR/FIXED bursts (WRAP behaves as INCR, reserved answers SLVERR).
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   ram_axi_aw*/w*/b*       write address, data and response channels
//   ram_axi_ar*/r*          read address and data channels
// Build option: BSTER_RAM_OUTREG_EN adds a flop stage on the R channel
// (first beat one cycle later, full throughput kept).
//
// state    | meaning
// W_IDLE   | awready high, waiting for a write address
// W_DATA   | wready high, writing one word per W handshake
// W_RESP   | bvalid high until bready
// R_IDLE   | arready high, waiting for a read address
// R_BURST  | presenting read beats, next beat after each R handshake
module bster_axi_ram
  import bster_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int RAM_STRB_WIDTH = RAM_DATA_WIDTH / 8,
  parameter int RAM_ID_WIDTH   = 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [RAM_ID_WIDTH-1:0]   ram_axi_awid,
  input  logic [RAM_ADDR_WIDTH-1:0] ram_axi_awaddr,
  input  logic [7:0]                ram_axi_awlen,
  input  logic [1:0]                ram_axi_awburst,
  input  logic                      ram_axi_awvalid,
  output logic                      ram_axi_awready,
  input  logic [RAM_DATA_WIDTH-1:0] ram_axi_wdata,
  input  logic [RAM_STRB_WIDTH-1:0] ram_axi_wstrb,
  input  logic                      ram_axi_wlast,
  input  logic                      ram_axi_wvalid,
  output logic                      ram_axi_wready,
  output logic [RAM_ID_WIDTH-1:0]   ram_axi_bid,
  output logic [1:0]                ram_axi_bresp,
  output logic                      ram_axi_bvalid,
  input  logic                      ram_axi_bready,
  input  logic [RAM_ID_WIDTH-1:0]   ram_axi_arid,
  input  logic [RAM_ADDR_WIDTH-1:0] ram_axi_araddr,
  input  logic [7:0]                ram_axi_arlen,
  input  logic [1:0]                ram_axi_arburst,
  input  logic                      ram_axi_arvalid,
  output logic                      ram_axi_arready,
  output logic [RAM_ID_WIDTH-1:0]   ram_axi_rid,
  output logic [RAM_DATA_WIDTH-1:0] ram_axi_rdata,
  output logic [1:0]                ram_axi_rresp,
  output logic                      ram_axi_rlast,
  output logic                      ram_axi_rvalid,
  input  logic                      ram_axi_rready
);

  localparam int SHIFT = $clog2(RAM_STRB_WIDTH);
  localparam int IDX_W = RAM_ADDR_WIDTH - SHIFT;

  logic [IDX_W-1:0] aw_idx, ar_idx;
  assign aw_idx = IDX_W'(ram_axi_awaddr >> SHIFT);
  assign ar_idx = IDX_W'(ram_axi_araddr >> SHIFT);

  // ---------------- write path ----------------
  write_state_t             wstate_q;
  logic                     awready_q, wready_q, bvalid_q;
  logic [RAM_ID_WIDTH-1:0]  bid_q;
  logic [1:0]               bresp_q;
  logic [IDX_W-1:0]         widx_q;
  logic [7:0]               wcnt_q;
  logic                     wstep_q, wrsvd_q, werr_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= AXI_RESP_OKAY;
      widx_q    <= '0;
      wcnt_q    <= '0;
      wstep_q   <= 1'b0;
      wrsvd_q   <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awready_q && ram_axi_awvalid) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= ram_axi_awid;
            widx_q    <= aw_idx;
            wcnt_q    <= ram_axi_awlen;
            wstep_q   <= burst_step(ram_axi_awburst);
            wrsvd_q   <= (ram_axi_awburst == AXI_BURST_RSVD);
            werr_q    <= (ram_axi_awburst == AXI_BURST_RSVD);
            wstate_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (ram_axi_wvalid) begin
            widx_q <= widx_q + IDX_W'(wstep_q);
            // Beat count comes from awlen; wlast only flags a protocol error.
            if (wcnt_q == 8'd0) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (werr_q || !ram_axi_wlast) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
              wstate_q <= W_RESP;
            end else begin
              wcnt_q <= wcnt_q - 8'd1;
              if (ram_axi_wlast) werr_q <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (ram_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  assign ram_axi_awready = awready_q;
  assign ram_axi_wready  = wready_q;
  assign ram_axi_bvalid  = bvalid_q;
  assign ram_axi_bid     = bid_q;
  assign ram_axi_bresp   = bresp_q;

  // Gated by areset so a beat presented on the reset edge is dropped.
  logic mem_we;
  assign mem_we = (wstate_q == W_DATA) && ram_axi_wvalid && !wrsvd_q && !areset;

  // ---------------- read path ----------------
  read_state_t              rstate_q;
  logic                     arready_q, rvalid_q, rlast_q;
  logic [RAM_ID_WIDTH-1:0]  rid_q;
  logic [IDX_W-1:0]         ridx_q;
  logic [7:0]               rcnt_q;
  logic                     rstep_q, rrsvd_q;
  logic                     s1_ready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      ridx_q    <= '0;
      rcnt_q    <= '0;
      rstep_q   <= 1'b0;
      rrsvd_q   <= 1'b0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arready_q && ram_axi_arvalid) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rlast_q   <= (ram_axi_arlen == 8'd0);
            rid_q     <= ram_axi_arid;
            rcnt_q    <= ram_axi_arlen;
            rstep_q   <= burst_step(ram_axi_arburst);
            rrsvd_q   <= (ram_axi_arburst == AXI_BURST_RSVD);
            // First word is fetched now, so the pointer runs one beat ahead.
            ridx_q    <= ar_idx + IDX_W'(burst_step(ram_axi_arburst));
            rstate_q  <= R_BURST;
          end
        end
        R_BURST: begin
          if (s1_ready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rstate_q  <= R_IDLE;
            end else begin
              ridx_q  <= ridx_q + IDX_W'(rstep_q);
              rcnt_q  <= rcnt_q - 8'd1;
              rlast_q <= (rcnt_q == 8'd1);
            end
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  logic                      mem_re;
  logic [IDX_W-1:0]          mem_raddr;
  logic [RAM_DATA_WIDTH-1:0] mem_rdata;

  assign mem_re = ((rstate_q == R_IDLE) && arready_q && ram_axi_arvalid) ||
                  ((rstate_q == R_BURST) && s1_ready && !rlast_q);
  assign mem_raddr = (rstate_q == R_IDLE) ? ar_idx : ridx_q;

  bster_ram_array #(
    .DATA_W (RAM_DATA_WIDTH),
    .IDX_W  (IDX_W),
    .STRB_W (RAM_STRB_WIDTH)
  ) u_array (
    .clk_i   (aclk),
    .we_i    (mem_we),
    .waddr_i (widx_q),
    .wstrb_i (ram_axi_wstrb),
    .wdata_i (ram_axi_wdata),
    .re_i    (mem_re),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  // Beat as seen straight out of the array; zeroed outside a valid beat so
  // reset and idle show rdata=0.
  logic [RAM_DATA_WIDTH-1:0] s1_rdata;
  logic [1:0]                s1_rresp;
  assign s1_rdata = (rvalid_q && !rrsvd_q) ? mem_rdata : '0;
  assign s1_rresp = (rvalid_q && rrsvd_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

`ifdef BSTER_RAM_OUTREG_EN
  logic                      or_valid_q, or_last_q;
  logic [RAM_ID_WIDTH-1:0]   or_id_q;
  logic [RAM_DATA_WIDTH-1:0] or_data_q;
  logic [1:0]                or_resp_q;

  // Pipeline stage: refills whenever empty or being drained this cycle.
  assign s1_ready = !or_valid_q || ram_axi_rready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      or_valid_q <= 1'b0;
      or_last_q  <= 1'b0;
      or_id_q    <= '0;
      or_data_q  <= '0;
      or_resp_q  <= AXI_RESP_OKAY;
    end else if (s1_ready) begin
      or_valid_q <= rvalid_q;
      or_last_q  <= rlast_q;
      or_id_q    <= rid_q;
      or_data_q  <= s1_rdata;
      or_resp_q  <= s1_rresp;
    end
  end

  assign ram_axi_rvalid = or_valid_q;
  assign ram_axi_rlast  = or_last_q;
  assign ram_axi_rid    = or_id_q;
  assign ram_axi_rdata  = or_data_q;
  assign ram_axi_rresp  = or_resp_q;
`else
  assign s1_ready       = ram_axi_rready;
  assign ram_axi_rvalid = rvalid_q;
  assign ram_axi_rlast  = rlast_q;
  assign ram_axi_rid    = rid_q;
  assign ram_axi_rdata  = s1_rdata;
  assign ram_axi_rresp  = s1_rresp;
`endif

  assign ram_axi_arready = arready_q;

endmodule

// File: tb/tb_bster_axi_ram.sv
module tb_bster_axi_ram;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  awid, arid, bid, rid;
  logic [15:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  int total = 0;
  int bad   = 0;

`ifdef BSTER_RAM_OUTREG_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  logic [31:0] rd_data [16];
  logic [7:0]  got_bid;
  logic [1:0]  got_bresp;

  always #5 aclk = ~aclk;

  bster_axi_ram dut (
    .aclk            (aclk),
    .areset          (areset),
    .ram_axi_awid    (awid),
    .ram_axi_awaddr  (awaddr),
    .ram_axi_awlen   (awlen),
    .ram_axi_awburst (awburst),
    .ram_axi_awvalid (awvalid),
    .ram_axi_awready (awready),
    .ram_axi_wdata   (wdata),
    .ram_axi_wstrb   (wstrb),
    .ram_axi_wlast   (wlast),
    .ram_axi_wvalid  (wvalid),
    .ram_axi_wready  (wready),
    .ram_axi_bid     (bid),
    .ram_axi_bresp   (bresp),
    .ram_axi_bvalid  (bvalid),
    .ram_axi_bready  (bready),
    .ram_axi_arid    (arid),
    .ram_axi_araddr  (araddr),
    .ram_axi_arlen   (arlen),
    .ram_axi_arburst (arburst),
    .ram_axi_arvalid (arvalid),
    .ram_axi_arready (arready),
    .ram_axi_rid     (rid),
    .ram_axi_rdata   (rdata),
    .ram_axi_rresp   (rresp),
    .ram_axi_rlast   (rlast),
    .ram_axi_rvalid  (rvalid),
    .ram_axi_rready  (rready)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [31:0] base, input logic [3:0] strb,
                           input int wlast_at, output logic [7:0] bid_o, output logic [1:0] bresp_o);
    int n;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin tick(); n++; end
    check_val("aw_ready", awready, 1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = 32'(base + i); wstrb = strb; wlast = (i == wlast_at); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 100) begin tick(); n++; end
      check_val("w_ready", wready, 1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 100) begin tick(); n++; end
    check_val("b_valid", bvalid, 1);
    bid_o = bid; bresp_o = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input bit toggle, input logic [1:0] exp_resp);
    int n, lat, beat, cyc, stall_err;
    bit stalled;
    logic [31:0] sd;
    logic sl;
    logic [1:0] sr;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin tick(); n++; end
    check_val("ar_ready", arready, 1);
    tick();
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 20) begin tick(); lat++; end
    check_val("r_latency", lat, EXP_LAT);
    beat = 0; cyc = 0; stall_err = 0; stalled = 0;
    sd = '0; sl = 1'b0; sr = '0;
    while (beat <= int'(len) && cyc < 200) begin
      rready = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (stalled && (rdata !== sd || rlast !== sl || rresp !== sr)) stall_err++;
      if (rvalid && rready) begin
        rd_data[beat] = rdata;
        check_val("r_last", rlast, (beat == int'(len)));
        check_val("r_id", rid, id);
        check_val("r_resp", rresp, exp_resp);
        beat++;
        stalled = 0;
      end else if (rvalid) begin
        stalled = 1; sd = rdata; sl = rlast; sr = rresp;
      end else begin
        stalled = 0;
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    check_val("r_beats", beat, int'(len) + 1);
    check_val("r_stable", stall_err, 0);
  endtask

  initial begin
    int bv;
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awburst = 2'b01; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
    tick(); tick(); tick();
    check_val("rst_awready", awready, 0);
    check_val("rst_wready", wready, 0);
    check_val("rst_bvalid", bvalid, 0);
    check_val("rst_arready", arready, 0);
    check_val("rst_rvalid", rvalid, 0);
    check_val("rst_b_fields", {bid, bresp}, 0);
    check_val("rst_r_fields", {rid, rdata, rresp, rlast}, 0);
    areset = 1'b0;

    // INCR burst, words 4..7
    axi_write(8'h05, 16'h0010, 8'd3, 2'b01, 32'hA0, 4'hF, 3, got_bid, got_bresp);
    check_val("t1_bid", got_bid, 8'h05);
    check_val("t1_bresp", got_bresp, 2'b00);
    axi_read(8'h05, 16'h0010, 8'd3, 2'b01, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) check_val("t1_rdata", rd_data[i], 32'hA0 + i);

    // byte strobes on word 2
    axi_write(8'h01, 16'h0008, 8'd0, 2'b01, 32'hFFFFFFFF, 4'hF, 0, got_bid, got_bresp);
    axi_write(8'h02, 16'h0008, 8'd0, 2'b01, 32'h11223344, 4'b0101, 0, got_bid, got_bresp);
    axi_read(8'h02, 16'h0008, 8'd0, 2'b01, 1'b0, 2'b00);
    check_val("t2_strb", rd_data[0], 32'hFF22FF44);

    // INCR wrap past the last word
    axi_write(8'h03, 16'hFFFC, 8'd1, 2'b01, 32'hB0, 4'hF, 1, got_bid, got_bresp);
    axi_read(8'h03, 16'hFFFC, 8'd0, 2'b01, 1'b0, 2'b00);
    check_val("t3_last_word", rd_data[0], 32'hB0);
    axi_read(8'h03, 16'h0000, 8'd0, 2'b01, 1'b0, 2'b00);
    check_val("t3_word0", rd_data[0], 32'hB1);
    axi_read(8'h04, 16'hFFFC, 8'd1, 2'b01, 1'b0, 2'b00);
    check_val("t3_rd_wrap0", rd_data[0], 32'hB0);
    check_val("t3_rd_wrap1", rd_data[1], 32'hB1);

    // len=7 read with rready toggling
    axi_write(8'h06, 16'h0100, 8'd7, 2'b01, 32'hC0, 4'hF, 7, got_bid, got_bresp);
    axi_read(8'h06, 16'h0100, 8'd7, 2'b01, 1'b1, 2'b00);
    for (int i = 0; i < 8; i++) check_val("t4_rdata", rd_data[i], 32'hC0 + i);

    // reserved burst: no write, SLVERR
    axi_write(8'h07, 16'h0010, 8'd3, 2'b11, 32'hD0, 4'hF, 3, got_bid, got_bresp);
    check_val("t5_rsvd_bresp", got_bresp, 2'b10);
    axi_read(8'h07, 16'h0010, 8'd3, 2'b01, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) check_val("t5_unchanged", rd_data[i], 32'hA0 + i);
    axi_read(8'h08, 16'h0010, 8'd1, 2'b11, 1'b0, 2'b10);
    check_val("t5_rsvd_rdata0", rd_data[0], 32'h0);
    check_val("t5_rsvd_rdata1", rd_data[1], 32'h0);

    // wlast early, then wlast missing on the final beat
    axi_write(8'h09, 16'h0200, 8'd3, 2'b01, 32'hE0, 4'hF, 1, got_bid, got_bresp);
    check_val("t5_early_wlast", got_bresp, 2'b10);
    axi_write(8'h0A, 16'h0210, 8'd1, 2'b01, 32'hE8, 4'hF, -1, got_bid, got_bresp);
    check_val("t5_no_wlast", got_bresp, 2'b10);
    axi_read(8'h09, 16'h0204, 8'd0, 2'b01, 1'b0, 2'b00);
    check_val("t5_early_data", rd_data[0], 32'hE1);

    // FIXED burst keeps hitting one word
    axi_write(8'h0B, 16'h0300, 8'd2, 2'b00, 32'hF0, 4'hF, 2, got_bid, got_bresp);
    check_val("t6_fixed_bresp", got_bresp, 2'b00);
    axi_read(8'h0B, 16'h0300, 8'd2, 2'b00, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) check_val("t6_fixed_rdata", rd_data[i], 32'hF2);

    // reset in the middle of a write burst
    axi_write(8'h0C, 16'h0404, 8'd0, 2'b01, 32'h77, 4'hF, 0, got_bid, got_bresp);
    awid = 8'h0D; awaddr = 16'h0400; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
    bv = 0;
    while (!awready && bv < 100) begin tick(); bv++; end
    check_val("t7_aw_ready", awready, 1);
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; wlast = 1'b0;
    check_val("t7_w_ready", wready, 1);
    tick();
    wdata = 32'h66;
    areset = 1'b1;
    tick(); tick();
    areset = 1'b0; wvalid = 1'b0; bready = 1'b1;
    bv = 0;
    for (int i = 0; i < 8; i++) begin
      if (bvalid) bv++;
      tick();
    end
    bready = 1'b0;
    check_val("t7_no_bvalid", bv, 0);
    axi_read(8'h0D, 16'h0400, 8'd1, 2'b01, 1'b0, 2'b00);
    check_val("t7_beat1_kept", rd_data[0], 32'h55);
    check_val("t7_beat2_dropped", rd_data[1], 32'h77);
    axi_write(8'h0E, 16'h0408, 8'd0, 2'b01, 32'h99, 4'hF, 0, got_bid, got_bresp);
    check_val("t7_next_bid", got_bid, 8'h0E);
    check_val("t7_next_bresp", got_bresp, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
